// File: rtl/delay_align_ctrl_if.sv
// Symbol-path and status bundle between the delay-align sequencer and its environment.
// The slave modport is the sequencer side; the master modport is the delay line / BER side.
interface delay_align_ctrl_if #(
    parameter int WIN_LOG2 = 10
);
    logic                sym_clk_en;
    logic                start;
    logic signed [1:0]   ref_sym;
    logic signed [1:0]   rx_sym;
    logic [7:0]          delay;
    logic                busy;
    logic                locked;
    logic [WIN_LOG2:0]   best_score;
    logic                lock_loss;

    modport master (
        output sym_clk_en, start, ref_sym, rx_sym,
        input  delay, busy, locked, best_score, lock_loss
    );

    modport slave (
        input  sym_clk_en, start, ref_sym, rx_sym,
        output delay, busy, locked, best_score, lock_loss
    );
endinterface

// File: rtl/delay_align_ctrl.sv
// Sweeps the symbol delay-line tap, scores each tap over a window and locks the best one.
// Optional DELAY_ALIGN_TRACK_EN: while locked, count mismatches and re-sweep on loss of lock.
module delay_align_ctrl #(
    parameter int WIN_LOG2    = 10,
    parameter int MAX_DELAY   = 255,
    parameter int SETTLE_SYMS = 4,
    parameter int LOSS_THRESH = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    delay_align_ctrl_if.slave bus
);
    localparam int            SW          = WIN_LOG2 + 1;
    localparam logic [SW-1:0] WIN_LAST    = SW'((2 ** WIN_LOG2) - 1);
    localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE_SYMS - 1);
    localparam logic [7:0]    MAX_TAP     = 8'(MAX_DELAY);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_NEXT,
        ST_LOCKED
    } state_t;

    state_t        state;
    logic [7:0]    delay_q;
    logic [7:0]    best_tap;
    logic          busy_q;
    logic          locked_q;
    logic          lock_loss_q;
    logic [SW-1:0] best_score_q;
    logic [SW-1:0] best;
    logic [SW-1:0] score;
    logic [SW-1:0] win_cnt;
    logic [3:0]    settle_cnt;

    logic          tick;
    logic          sym_match;
    logic          better;
    logic          loss_event;
    logic          sweep_start;

    assign tick      = bus.sym_clk_en;
    assign sym_match = (bus.ref_sym == bus.rx_sym);
    // Strict compare: on a tie the earlier (lower) tap stays the best.
    assign better    = (score > best);

`ifdef DELAY_ALIGN_TRACK_EN
    logic [SW-1:0] miss_cnt;
    logic [SW-1:0] trk_cnt;
    logic [SW-1:0] miss_next;

    assign miss_next  = miss_cnt + SW'(!sym_match);
    assign loss_event = (state == ST_LOCKED) && tick && (trk_cnt == WIN_LAST) &&
                        (int'(miss_next) >= LOSS_THRESH);
`else
    assign loss_event = 1'b0;
`endif

    // A loss of lock re-enters the sweep exactly like an external start.
    assign sweep_start = bus.start || loss_event;

    // NOTE: every register here is state, so all assignments are non-blocking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            delay_q      <= '0;
            best_tap     <= '0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            lock_loss_q  <= 1'b0;
            best_score_q <= '0;
            best         <= '0;
            score        <= '0;
            win_cnt      <= '0;
            settle_cnt   <= '0;
`ifdef DELAY_ALIGN_TRACK_EN
            miss_cnt     <= '0;
            trk_cnt      <= '0;
`endif
        end else begin
            lock_loss_q <= loss_event;
            if (sweep_start) begin
                state      <= ST_SETTLE;
                delay_q    <= '0;
                best       <= '0;
                best_tap   <= '0;
                score      <= '0;
                win_cnt    <= '0;
                settle_cnt <= '0;
                busy_q     <= 1'b1;
                locked_q   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_SETTLE: begin
                        if (tick) begin
                            if (settle_cnt == SETTLE_LAST) begin
                                state      <= ST_MEASURE;
                                settle_cnt <= '0;
                                score      <= '0;
                                win_cnt    <= '0;
                            end else begin
                                settle_cnt <= settle_cnt + 4'd1;
                            end
                        end
                    end
                    ST_MEASURE: begin
                        if (tick) begin
                            score   <= score + SW'(sym_match);
                            win_cnt <= win_cnt + SW'(1);
                            if (win_cnt == WIN_LAST) state <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        if (better) begin
                            best     <= score;
                            best_tap <= delay_q;
                        end
                        if (delay_q == MAX_TAP) begin
                            delay_q      <= better ? delay_q : best_tap;
                            best_score_q <= better ? score : best;
                            busy_q       <= 1'b0;
                            locked_q     <= 1'b1;
                            state        <= ST_LOCKED;
`ifdef DELAY_ALIGN_TRACK_EN
                            miss_cnt     <= '0;
                            trk_cnt      <= '0;
`endif
                        end else begin
                            delay_q    <= delay_q + 8'd1;
                            settle_cnt <= '0;
                            state      <= ST_SETTLE;
                        end
                    end
                    ST_LOCKED: begin
`ifdef DELAY_ALIGN_TRACK_EN
                        if (tick) begin
                            if (trk_cnt == WIN_LAST) begin
                                miss_cnt <= '0;
                                trk_cnt  <= '0;
                            end else begin
                                miss_cnt <= miss_next;
                                trk_cnt  <= trk_cnt + SW'(1);
                            end
                        end
`endif
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.delay      = delay_q;
    assign bus.busy       = busy_q;
    assign bus.locked     = locked_q;
    assign bus.best_score = best_score_q;
    assign bus.lock_loss  = lock_loss_q;
endmodule

// File: tb/tb_delay_align_ctrl.sv
// Scoreboard bench for delay_align_ctrl: a delay-line model feeds ref/rx symbols,
// expected lock results are queued at sweep start and popped when locked rises.
module tb_delay_align_ctrl;
    localparam int WIN_LOG2    = 4;
    localparam int MAX_DELAY   = 15;
    localparam int SETTLE_SYMS = 2;
    localparam int LOSS_THRESH = 8;
    localparam int HIST        = 32;
    localparam int FULL_SCORE  = 16;
    localparam int SWEEP_CLKS  = 3000;

    typedef struct {
        int tap;
        int score;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;

    delay_align_ctrl_if #(.WIN_LOG2(WIN_LOG2)) bus ();

    delay_align_ctrl #(
        .WIN_LOG2   (WIN_LOG2),
        .MAX_DELAY  (MAX_DELAY),
        .SETTLE_SYMS(SETTLE_SYMS),
        .LOSS_THRESH(LOSS_THRESH)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int   n_checks    = 0;
    int   n_pass      = 0;
    exp_t exp_q[$];
    exp_t exp_cur;
    int   rx_lag      = 7;
    bit   periodic    = 1'b0;
    bit   en_hold     = 1'b0;
    bit   saw_loss    = 1'b0;
    bit   prev_locked = 1'b0;
    int   phase       = 0;
    int   pidx        = 0;
    logic signed [1:0] hist [HIST];
    logic signed [1:0] pat  [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};

    task automatic check(input string name, input logic [31:0] act, input int expv);
        n_checks++;
        if (act === 32'(expv)) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    // Delay-line model: rx lags the source by rx_lag symbols, ref by the DUT's tap.
    initial begin : sym_gen
        for (int i = 0; i < HIST; i++) hist[i] = 2'b00;
        bus.sym_clk_en = 1'b0;
        bus.ref_sym    = 2'b00;
        bus.rx_sym     = 2'b00;
        forever begin
            @(negedge clk);
            if (bus.sym_clk_en) begin
                for (int i = HIST - 1; i > 0; i--) hist[i] = hist[i-1];
                if (periodic) begin
                    hist[0] = pat[pidx];
                    pidx    = (pidx + 1) % 6;
                end else begin
                    hist[0] = 2'($urandom_range(0, 3));
                end
            end
            phase          = (phase + 1) % 4;
            bus.sym_clk_en = !en_hold && (phase == 0);
            bus.ref_sym    = hist[bus.delay[4:0]];
            bus.rx_sym     = hist[rx_lag];
        end
    end

    // NOTE: outputs are sampled on the falling edge, clear of the active edge.
    always @(negedge clk) begin
        if (bus.lock_loss === 1'b1) saw_loss = 1'b1;
        if (bus.locked === 1'b1 && !prev_locked) begin
            if (exp_q.size() == 0) begin
                check("unexpected_lock", 32'(exp_q.size()), 1);
            end else begin
                exp_cur = exp_q.pop_front();
                check("lock_delay", 32'(bus.delay), exp_cur.tap);
                check("lock_score", 32'(bus.best_score), exp_cur.score);
            end
        end
        prev_locked = (bus.locked === 1'b1);
    end

    task automatic begin_sweep(input int lag, input bit per, input int exp_tap);
        @(negedge clk);
        #1;
        rx_lag   = lag;
        periodic = per;
        if (exp_tap >= 0) exp_q.push_back('{tap: exp_tap, score: FULL_SCORE});
        bus.start = 1'b1;
        @(negedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_lock(input string name, input int budget);
        int k = 0;
        while (bus.locked !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_locked"}, 32'(bus.locked), 1);
        check({name, "_busy"}, 32'(bus.busy), 0);
    endtask

    task automatic wait_delay(input string name, input int tap, input int budget);
        int k = 0;
        while (bus.delay !== 8'(tap) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_reach_tap"}, 32'(bus.delay), tap);
    endtask

    initial begin : main
        int k;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_delay", 32'(bus.delay), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_best_score", 32'(bus.best_score), 0);
        check("rst_lock_loss", 32'(bus.lock_loss), 0);
        #1 reset_n = 1'b1;

        // Random data, rx lags by 7.
        begin_sweep(7, 1'b0, 7);
        wait_lock("t1", SWEEP_CLKS);

        // Period-6 data: taps 3, 9 and 15 all score 16, lowest wins.
        begin_sweep(3, 1'b1, 3);
        wait_lock("t2", SWEEP_CLKS);

        // Reset in the middle of measuring tap 5.
        begin_sweep(7, 1'b0, -1);
        wait_delay("t3", 5, SWEEP_CLKS);
        repeat (14) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t3_rst_delay", 32'(bus.delay), 0);
        check("t3_rst_busy", 32'(bus.busy), 0);
        check("t3_rst_locked", 32'(bus.locked), 0);
        check("t3_rst_best_score", 32'(bus.best_score), 0);
        check("t3_rst_lock_loss", 32'(bus.lock_loss), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (200) @(negedge clk);
        check("t3_idle_busy", 32'(bus.busy), 0);
        check("t3_idle_locked", 32'(bus.locked), 0);
        check("t3_idle_delay", 32'(bus.delay), 0);
        begin_sweep(5, 1'b0, 5);
        wait_lock("t3", SWEEP_CLKS);

        // Restart mid-sweep at tap 10.
        begin_sweep(11, 1'b0, 11);
        wait_delay("t4", 10, SWEEP_CLKS);
        #1 bus.start = 1'b1;
        @(negedge clk);
        check("t4_restart_delay", 32'(bus.delay), 0);
        check("t4_restart_busy", 32'(bus.busy), 1);
        #1 bus.start = 1'b0;
        wait_lock("t4", SWEEP_CLKS);

        // Symbol enable held low for 100 clk while measuring tap 6.
        begin_sweep(2, 1'b0, 2);
        wait_delay("t5", 6, SWEEP_CLKS);
        repeat (14) @(negedge clk);
        #1 en_hold = 1'b1;
        repeat (100) @(negedge clk);
        check("t5_frozen_delay", 32'(bus.delay), 6);
        check("t5_frozen_busy", 32'(bus.busy), 1);
        #1 en_hold = 1'b0;
        wait_lock("t5", SWEEP_CLKS);

        // Receive path slips by 3 symbols while locked at tap 2.
        saw_loss = 1'b0;
`ifdef DELAY_ALIGN_TRACK_EN
        #1;
        rx_lag = 5;
        exp_q.push_back('{tap: 5, score: FULL_SCORE});
        k = 0;
        while (!saw_loss && k < 2 * FULL_SCORE * 4 + 8) begin
            @(negedge clk);
            k++;
        end
        check("t6_lock_loss_seen", 32'(saw_loss), 1);
        wait_lock("t6", SWEEP_CLKS);
`else
        #1 rx_lag = 5;
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            k++;
        end
        check("hold_locked", 32'(bus.locked), 1);
        check("hold_delay", 32'(bus.delay), 2);
        check("hold_no_lock_loss", 32'(saw_loss), 0);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
